operand_buffer: RTL and testbench
=================================

# operand_buffer

Parametrised, double-buffered operand store for the systolic array: holds one N×N weight matrix and one N×N input matrix per bank, filled by a byte-serial valid/ready stream with an auto-incrementing write pointer. The array reads the active bank as flat vectors and releases it with `consume`. The next operand set loads into the shadow bank meanwhile. Sits between the host load interface in `tt_um_tpu` and the MAC array, replacing the fixed 2×2 single-bank store.

## Interface
- `N`, 2, matrix dimension; elements per matrix = N*N.
- `DATA_W`, 8, element width in bits.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  load beat present.
- `in_ready`  out  1  buffer can accept a beat this cycle.
- `in_data`  in  DATA_W  load beat payload.
- `consume`  in  1  array has finished with the active operand set.
- `operands_valid`  out  1  active bank is full; outputs are stable and meaningful.
- `weights`  out  N*N*DATA_W  active weight matrix, row-major, element r*N+c at [(r*N+c)*DATA_W +: DATA_W].
- `inputs`  out  N*N*DATA_W  active input matrix, same packing.
- `fill_count`  out  $clog2(2*N*N+1)  beats written into the bank currently loading.

## Operation
- Per-bank storage: 2*N*N elements. Slots 0..N*N-1 hold weights and slots N*N..2*N*N-1 hold inputs, in arrival order. The stream is all weights row-major, then all inputs row-major.
- State: `load_bank`, `rd_bank` (1 bit each), `bank_full[1:0]`, `wr_ptr` (0..2*N*N-1).
- `in_ready = !bank_full[load_bank]`.
- Beat accepted when `in_valid && in_ready`:
  - Write slot `wr_ptr` of `load_bank`.
  - If `wr_ptr == 2*N*N-1`: set `wr_ptr` to 0, set `bank_full[load_bank]`, and toggle `load_bank`.
  - Otherwise increment `wr_ptr`.
- `operands_valid = bank_full[rd_bank]`. `weights`/`inputs` show the `rd_bank` contents when valid and are all-zero when not valid.
- `consume` with `operands_valid` high: clear `bank_full[rd_bank]` and toggle `rd_bank`.
- `consume` with `operands_valid` low: ignored, no state change.
- Same cycle, a final beat into one bank and a `consume` of the other: both take effect.
- A full bank is never written, so the outputs cannot change while `operands_valid` is high unless `consume` fires.
- `fill_count = wr_ptr`. It returns to 0 on bank completion.
- Reset: all storage zeroed, `wr_ptr`=0, `load_bank`=`rd_bank`=0, `bank_full`=0.
  - Outputs after reset: `in_ready`=1, `operands_valid`=0, `weights`=`inputs`=0, `fill_count`=0.
- Reset mid-load discards the partial set. Reset overrides every simultaneous beat and `consume`.

## Timing
- `in_ready`, `operands_valid`, `weights`, `inputs`, `fill_count` are functions of registered state only; there is no combinational path from `in_valid`, `in_data` or `consume`.
- Final beat accepted at edge t, with `rd_bank` equal to that bank: `operands_valid`=1 in the cycle after edge t.
- `consume` at edge t with the other bank full: new operands are visible and `operands_valid` stays 1 in the cycle after edge t. If the other bank is not full, `operands_valid`=0 after edge t.
- Sustained throughput: one beat per cycle while a bank is free. Zero bubbles at a bank boundary if the next bank is empty.
- With both banks full: `in_ready`=0. It returns to 1 in the cycle after the `consume` edge.

## Configuration
- `OPERAND_BUFFER_DOUBLE_BUF_EN` defined: two banks, behaviour as above.
- Undefined: one bank only, and `load_bank`/`rd_bank` are constant 0.
  - `in_ready` is low whenever `operands_valid` is high, so loading the next set starts only after `consume`.
  - Storage and bank-select muxing are halved; the port list is unchanged.

## Structure
- `tpu_pkg`:
  - `DATA_W` default.
  - Helper function `elem_idx(r, c, N)`.
  - Localparam convention for `ELEMS = N*N` and `SLOTS = 2*N*N`.
  - Shared with the array and the top level.
- Sub-module `operand_bank`: one bank with write-enable, write index, write data, and flat `weights`/`inputs` read vectors. Instantiated once or twice under the macro. `operand_buffer` holds the pointers, full flags, handshake and output gating.

## Test plan
- Reset: assert `rst` for 2 cycles mid-load (after 3 beats) -> `in_ready`=1, `operands_valid`=0, `fill_count`=0, outputs 0. A fresh 8-beat load then reproduces its own data with no stale bytes.
- N=2 load of 01..08 back-to-back -> `operands_valid`=1 the cycle after beat 8, `weights`=0x04030201, `inputs`=0x08070605, `fill_count` back to 0.
- Double buffer: load 01..08 then 11..18 without `consume` -> `in_ready`=0 after beat 16. `consume` -> next cycle `weights`=0x14131211, `in_ready`=1.
- Simultaneous: 16th beat accepted on the same edge as `consume` of bank 0 -> next cycle bank-1 data valid, `in_ready`=1, `load_bank`=0.
- `consume` while `operands_valid`=0 -> no state change; the following load still lands in bank 0.
- Macro undefined: after 8 beats `in_ready`=0 until `consume`. Beats presented meanwhile are not accepted and `fill_count` stays 0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared systolic-array definitions: default element width, per-matrix and
// per-bank element counts, and the row-major element index helper.
package tpu_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Elements in one N x N matrix.
    function automatic int elems(input int n);
        return n * n;
    endfunction

    // Slots in one operand bank: a weight matrix followed by an input matrix.
    function automatic int slots(input int n);
        return 2 * n * n;
    endfunction

    // Row-major position of element (r, c) in an N x N matrix.
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/operand_buffer_if.sv
// Load stream and operand read-out bundle between the host loader, the
// operand buffer and the MAC array.
interface operand_buffer_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(2 * N * N + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     consume;
    logic                     operands_valid;
    logic [N*N*DATA_W-1:0]    weights;
    logic [N*N*DATA_W-1:0]    inputs;
    logic [CNT_W-1:0]         fill_count;

    // Loader/array side.
    modport master (
        output in_valid, in_data, consume,
        input  in_ready, operands_valid, weights, inputs, fill_count
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, consume,
        output in_ready, operands_valid, weights, inputs, fill_count
    );

endinterface

// File: rtl/operand_bank.sv
// One operand bank: 2*N*N element slots (weights first, then inputs), written
// one slot per cycle and read as two flat row-major matrix vectors.
module operand_bank
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = DEFAULT_DATA_W,
    localparam int IDX_W = $clog2(2 * N * N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [N*N*DATA_W-1:0] weights,
    output logic [N*N*DATA_W-1:0] inputs
);
    localparam int ELEMS = elems(N);
    localparam int SLOTS = slots(N);

    logic [DATA_W-1:0] mem [SLOTS];

    // NOTE: the storage is reset deliberately; a load cut short by reset must
    // never leave stale bytes that a later set could expose.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // NOTE: both vectors get a full default before the loop so no bit can be
    // left unassigned on some path and infer a latch.
    always_comb begin
        weights = '0;
        inputs  = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                weights[elem_idx(r, c, N)*DATA_W +: DATA_W] = mem[elem_idx(r, c, N)];
                inputs[elem_idx(r, c, N)*DATA_W +: DATA_W]  = mem[ELEMS + elem_idx(r, c, N)];
            end
        end
    end

endmodule

// File: rtl/operand_buffer.sv
// Double-buffered N x N weight/input operand store fed by a byte-serial stream.
// Define OPERAND_BUFFER_DOUBLE_BUF_EN for two banks; otherwise one bank only.
module operand_buffer
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    operand_buffer_if.slave bus
);
    localparam int ELEMS = elems(N);
    localparam int SLOTS = slots(N);
    localparam int PTR_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);
`ifdef OPERAND_BUFFER_DOUBLE_BUF_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    logic [PTR_W-1:0]        wr_ptr;
    logic [1:0]              bank_full;
    logic [1:0]              bank_full_nxt;
    logic                    load_bank;
    logic                    rd_bank;
    logic                    in_ready;
    logic                    operands_valid;
    logic                    accept;
    logic                    last_beat;
    logic                    release_bank;
    logic [ELEMS*DATA_W-1:0] bank_w [NUM_BANKS];
    logic [ELEMS*DATA_W-1:0] bank_i [NUM_BANKS];
    logic [ELEMS*DATA_W-1:0] sel_w;
    logic [ELEMS*DATA_W-1:0] sel_i;

    assign in_ready       = !bank_full[load_bank];
    assign operands_valid = bank_full[rd_bank];
    assign accept         = bus.in_valid && in_ready;
    assign last_beat      = (wr_ptr == PTR_W'(SLOTS - 1));
    assign release_bank   = bus.consume && operands_valid;

    // Filling and releasing always hit different banks (one is full, the
    // other is not), so both updates can apply in the same cycle.
    always_comb begin
        bank_full_nxt = bank_full;
        if (accept && last_beat) begin
            bank_full_nxt[load_bank] = 1'b1;
        end
        if (release_bank) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            bank_full <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            if (accept) begin
                wr_ptr <= last_beat ? '0 : wr_ptr + 1'b1;
            end
        end
    end

`ifdef OPERAND_BUFFER_DOUBLE_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_bank <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            if (accept && last_beat) begin
                load_bank <= !load_bank;
            end
            if (release_bank) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    assign sel_w = bank_w[rd_bank];
    assign sel_i = bank_i[rd_bank];
`else
    // Single bank: loading and reading share bank 0, so in_ready falls
    // whenever the operands are valid.
    assign load_bank = 1'b0;
    assign rd_bank   = 1'b0;
    assign sel_w     = bank_w[0];
    assign sel_i     = bank_i[0];
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic wr_en;
        assign wr_en = accept && (load_bank == 1'(b));

        operand_bank #(
            .N      (N),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en),
            .wr_idx  (wr_ptr),
            .wr_data (bus.in_data),
            .weights (bank_w[b]),
            .inputs  (bank_i[b])
        );
    end

    // Operand vectors read as zero unless the active bank holds a full set.
    assign bus.in_ready       = in_ready;
    assign bus.operands_valid = operands_valid;
    assign bus.weights        = operands_valid ? sel_w : '0;
    assign bus.inputs         = operands_valid ? sel_i : '0;
    assign bus.fill_count     = CNT_W'(wr_ptr);

endmodule

// File: tb/tb_operand_buffer.sv
// Directed bench for operand_buffer (N=2, DATA_W=8); the bank-specific
// scenarios follow OPERAND_BUFFER_DOUBLE_BUF_EN.
module tb_operand_buffer;
    localparam int N      = 2;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    operand_buffer_if #(.N(N), .DATA_W(DATA_W)) bus ();

    operand_buffer #(.N(N), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One beat; waits (bounded) for in_ready, returns 1 time unit after the edge.
    task automatic send_beat(input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL beat_ready_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, waited);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic load_set(input logic [7:0] base);
        for (int i = 1; i <= 8; i++) send_beat(base + 8'(i));
    endtask

    task automatic pulse_consume();
        @(negedge clk);
        bus.consume = 1'b1;
        @(posedge clk);
        #1 bus.consume = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 5;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.operands_valid); end
        if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL rst_fill: got %0d want 0", bus.fill_count); end
        if (bus.weights !== 32'h0) begin miscompares++; $display("FAIL rst_weights: got %h want 0", bus.weights); end
        if (bus.inputs !== 32'h0) begin miscompares++; $display("FAIL rst_inputs: got %h want 0", bus.inputs); end
        send_beat(8'hAA); send_beat(8'hBB); send_beat(8'hCC);
        vectors++;
        if (bus.fill_count !== 4'd3) begin miscompares++; $display("FAIL partial_fill: got %0d want 3", bus.fill_count); end
        // Reset while a beat is also presented: the beat must be dropped.
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hDD;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; bus.in_valid = 1'b0;
        vectors += 3;
        if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL midload_rst_fill: got %0d want 0", bus.fill_count); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midload_rst_ready: got %b want 1", bus.in_ready); end
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL midload_rst_valid: got %b want 0", bus.operands_valid); end
        load_set(8'h30);
        vectors += 3;
        if (bus.operands_valid !== 1'b1) begin miscompares++; $display("FAIL fresh_valid: got %b want 1", bus.operands_valid); end
        if (bus.weights !== 32'h34333231) begin miscompares++; $display("FAIL fresh_weights: got %h want 34333231", bus.weights); end
        if (bus.inputs !== 32'h38373635) begin miscompares++; $display("FAIL fresh_inputs: got %h want 38373635", bus.inputs); end
        pulse_consume();
    endtask

    task automatic test_load();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'(i));
            vectors += 2;
            if (bus.fill_count !== 4'(i % 8)) begin miscompares++; $display("FAIL load_fill_%0d: got %0d want %0d", i, bus.fill_count, i % 8); end
            if (bus.operands_valid !== (i == 8)) begin miscompares++; $display("FAIL load_valid_%0d: got %b want %b", i, bus.operands_valid, i == 8); end
        end
        vectors += 2;
        if (bus.weights !== 32'h04030201) begin miscompares++; $display("FAIL load_weights: got %h want 04030201", bus.weights); end
        if (bus.inputs !== 32'h08070605) begin miscompares++; $display("FAIL load_inputs: got %h want 08070605", bus.inputs); end
        pulse_consume();
        vectors += 2;
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL load_consumed_valid: got %b want 0", bus.operands_valid); end
        if (bus.weights !== 32'h0) begin miscompares++; $display("FAIL load_consumed_weights: got %h want 0", bus.weights); end
    endtask

    task automatic test_consume_idle();
        do_reset();
        pulse_consume();
        vectors += 3;
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL idle_consume_valid: got %b want 0", bus.operands_valid); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_consume_ready: got %b want 1", bus.in_ready); end
        if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL idle_consume_fill: got %0d want 0", bus.fill_count); end
        load_set(8'hA0);
        vectors += 2;
        if (bus.operands_valid !== 1'b1) begin miscompares++; $display("FAIL idle_then_load_valid: got %b want 1", bus.operands_valid); end
        if (bus.weights !== 32'hA4A3A2A1) begin miscompares++; $display("FAIL idle_then_load_weights: got %h want a4a3a2a1", bus.weights); end
        pulse_consume();
    endtask

`ifdef OPERAND_BUFFER_DOUBLE_BUF_EN
    task automatic test_double_buffer();
        do_reset();
        load_set(8'h00);
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL dbl_ready_after_8: got %b want 1", bus.in_ready); end
        load_set(8'h10);
        vectors += 3;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL dbl_ready_after_16: got %b want 0", bus.in_ready); end
        if (bus.weights !== 32'h04030201) begin miscompares++; $display("FAIL dbl_hold_weights: got %h want 04030201", bus.weights); end
        if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL dbl_fill: got %0d want 0", bus.fill_count); end
        pulse_consume();
        vectors += 4;
        if (bus.operands_valid !== 1'b1) begin miscompares++; $display("FAIL dbl_swap_valid: got %b want 1", bus.operands_valid); end
        if (bus.weights !== 32'h14131211) begin miscompares++; $display("FAIL dbl_swap_weights: got %h want 14131211", bus.weights); end
        if (bus.inputs !== 32'h18171615) begin miscompares++; $display("FAIL dbl_swap_inputs: got %h want 18171615", bus.inputs); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL dbl_swap_ready: got %b want 1", bus.in_ready); end
        pulse_consume();
        vectors++;
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL dbl_drained_valid: got %b want 0", bus.operands_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load_set(8'h00);
        for (int i = 1; i <= 7; i++) send_beat(8'h10 + 8'(i));
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h18; bus.consume = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.consume = 1'b0;
        vectors += 4;
        if (bus.operands_valid !== 1'b1) begin miscompares++; $display("FAIL sim_valid: got %b want 1", bus.operands_valid); end
        if (bus.weights !== 32'h14131211) begin miscompares++; $display("FAIL sim_weights: got %h want 14131211", bus.weights); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL sim_ready: got %b want 1", bus.in_ready); end
        if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL sim_fill: got %0d want 0", bus.fill_count); end
        // The next set must land in bank 0 and queue behind bank 1.
        load_set(8'h20);
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL sim_both_full_ready: got %b want 0", bus.in_ready); end
        pulse_consume();
        vectors += 2;
        if (bus.weights !== 32'h24232221) begin miscompares++; $display("FAIL sim_bank0_weights: got %h want 24232221", bus.weights); end
        if (bus.inputs !== 32'h28272625) begin miscompares++; $display("FAIL sim_bank0_inputs: got %h want 28272625", bus.inputs); end
        pulse_consume();
    endtask
`else
    task automatic test_single_bank();
        do_reset();
        load_set(8'h00);
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_full: got %b want 0", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors += 2;
            if (bus.fill_count !== 4'd0) begin miscompares++; $display("FAIL single_blocked_fill_%0d: got %0d want 0", i, bus.fill_count); end
            if (bus.weights !== 32'h04030201) begin miscompares++; $display("FAIL single_blocked_weights_%0d: got %h want 04030201", i, bus.weights); end
        end
        bus.in_valid = 1'b0;
        pulse_consume();
        vectors += 2;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL single_consumed_ready: got %b want 1", bus.in_ready); end
        if (bus.operands_valid !== 1'b0) begin miscompares++; $display("FAIL single_consumed_valid: got %b want 0", bus.operands_valid); end
        load_set(8'h10);
        vectors += 2;
        if (bus.weights !== 32'h14131211) begin miscompares++; $display("FAIL single_reload_weights: got %h want 14131211", bus.weights); end
        if (bus.inputs !== 32'h18171615) begin miscompares++; $display("FAIL single_reload_inputs: got %h want 18171615", bus.inputs); end
        pulse_consume();
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.consume  = 1'b0;
        test_reset();
        test_load();
        test_consume_idle();
`ifdef OPERAND_BUFFER_DOUBLE_BUF_EN
        test_double_buffer();
        test_simultaneous();
`else
        test_single_bank();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
